// File: rtl/chacha20_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chacha20_pkg: widths, sigma constants, sequencer states, state assembly   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package chacha20_pkg;

  localparam int KEY_W   = 256;
  localparam int NONCE_W = 96;
  localparam int CTR_W   = 32;
  localparam int BLOCK_W = 512;

  // "expand 32-byte k" as four little-endian words
  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_HOLD  = 3'd4
  } seq_state_t;

  // Word i of the result sits at bits [32i+31:32i].
  function automatic logic [BLOCK_W-1:0] build_state(
    input logic [KEY_W-1:0]   key,
    input logic [NONCE_W-1:0] nonce,
    input logic [CTR_W-1:0]   ctr
  );
    return {nonce, ctr, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/chacha20_keystream_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chacha20_keystream_sequencer: drives a serial ChaCha20 encoder and       |
// | streams 512-bit keystream blocks over valid/ready. Revision: 1.0          |
// +--------------------------------------------------------------------------+
module chacha20_keystream_sequencer
  import chacha20_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               key_load,
  input  logic [KEY_W-1:0]   key,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0]   counter_init,
  output logic               ks_valid,
  input  logic               ks_ready,
  output logic [BLOCK_W-1:0] ks_data,
  output logic               busy,
  output logic               exhausted,
  output logic               error,
  output logic               enc_clear,
  output logic               enc_set_state,
  output logic               enc_start_round,
  output logic [BLOCK_W-1:0] enc_round_input,
  input  logic [BLOCK_W-1:0] enc_round_output,
  input  logic               enc_finished
);

  localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam bit WD_EN = (WATCHDOG_CYCLES > 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((WATCHDOG_CYCLES > 0) ? WATCHDOG_CYCLES - 1 : 0);

  seq_state_t         r_state, w_state;
  logic [KEY_W-1:0]   r_key, w_key;
  logic [NONCE_W-1:0] r_nonce, w_nonce;
  logic [CTR_W-1:0]   r_counter, w_counter;
  logic [BLOCK_W-1:0] r_data, w_data;
  logic [WD_W-1:0]    r_wd, w_wd;
  logic               r_valid, w_valid;
  logic               r_exhausted, w_exhausted;
  logic               r_error, w_error;
  logic               r_clear, w_clear;
  logic               r_restart, w_restart;
  logic               r_set, w_set;
  logic               r_start, w_start;
  logic               r_busy, w_busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_nonce     <= '0;
      r_counter   <= '0;
      r_data      <= '0;
      r_wd        <= '0;
      r_valid     <= 1'b0;
      r_exhausted <= 1'b0;
      r_error     <= 1'b0;
      r_clear     <= 1'b0;
      r_restart   <= 1'b0;
      r_set       <= 1'b0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_key       <= w_key;
      r_nonce     <= w_nonce;
      r_counter   <= w_counter;
      r_data      <= w_data;
      r_wd        <= w_wd;
      r_valid     <= w_valid;
      r_exhausted <= w_exhausted;
      r_error     <= w_error;
      r_clear     <= w_clear;
      r_restart   <= w_restart;
      r_set       <= w_set;
      r_start     <= w_start;
      r_busy      <= w_busy;
    end
  end

  // Control outputs are decoded from the next state so each is a clean register.
  always_comb begin
    w_state     = r_state;
    w_key       = r_key;
    w_nonce     = r_nonce;
    w_counter   = r_counter;
    w_data      = r_data;
    w_wd        = r_wd;
    w_valid     = r_valid;
    w_exhausted = r_exhausted;
    w_error     = r_error;
    w_clear     = 1'b0;
    w_restart   = 1'b0;

    if (key_load) begin
      // Rekey discards everything in flight; the clear cycle precedes LOAD.
      w_key       = key;
      w_nonce     = nonce;
      w_counter   = counter_init;
      w_valid     = 1'b0;
      w_exhausted = 1'b0;
      w_error     = 1'b0;
      w_clear     = 1'b1;
      w_restart   = 1'b1;
      w_state     = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (r_restart) w_state = ST_LOAD;
        ST_LOAD:  w_state = ST_START;
        ST_START: begin
          w_state = ST_BUSY;
          w_wd    = '0;
        end
        ST_BUSY: begin
          if (enc_finished) begin
            w_data  = enc_round_output;
            w_valid = 1'b1;
            w_state = ST_HOLD;
            if (r_counter == {CTR_W{1'b1}}) w_exhausted = 1'b1;
            else                            w_counter   = r_counter + CTR_W'(1);
          end else if (WD_EN && (r_wd == WD_LAST)) begin
            w_error = 1'b1;
            w_clear = 1'b1;
            w_state = ST_IDLE;
          end else begin
            w_wd = r_wd + WD_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_valid && ks_ready) begin
            w_valid = 1'b0;
            w_state = r_exhausted ? ST_IDLE : ST_LOAD;
          end
        end
        default: w_state = ST_IDLE;
      endcase
    end

    w_set   = (w_state == ST_LOAD);
    w_start = (w_state == ST_START);
    w_busy  = (w_state == ST_LOAD) || (w_state == ST_START) || (w_state == ST_BUSY);
  end

  assign ks_valid        = r_valid;
  assign ks_data         = r_data;
  assign busy            = r_busy;
  assign exhausted       = r_exhausted;
  assign error           = r_error;
  assign enc_clear       = r_clear;
  assign enc_set_state   = r_set;
  assign enc_start_round = r_start;
  assign enc_round_input = build_state(r_key, r_nonce, r_counter);

endmodule
`default_nettype wire

// File: tb/tb_chacha20_keystream_sequencer.sv
`default_nettype none
// Directed bench for chacha20_keystream_sequencer with a behavioural ChaCha20 encoder.
module tb_chacha20_keystream_sequencer;

  localparam int LAT = 10;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_load = 1'b0;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  counter_init = '0;
  logic         ks_valid;
  logic         ks_ready = 1'b0;
  logic [511:0] ks_data;
  logic         busy, exhausted, error;
  logic         enc_clear, enc_set_state, enc_start_round;
  logic [511:0] enc_round_input;
  logic [511:0] enc_round_output;
  logic         enc_finished;

  logic         hang = 1'b0;
  logic         inj = 1'b0;
  logic         m_fin = 1'b0;
  logic         m_run = 1'b0;
  int           m_cnt = 0;
  logic [511:0] m_in = '0;
  logic [511:0] m_out = '0;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0, v_cnt = 0, st_cnt = 0, set_cnt = 0, clr_cnt = 0;
  int hs0, v0, st0, set0, clr0;
  logic [511:0] last_data = '0;

  chacha20_keystream_sequencer #(.WATCHDOG_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n), .key_load(key_load), .key(key), .nonce(nonce),
    .counter_init(counter_init), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
    .busy(busy), .exhausted(exhausted), .error(error), .enc_clear(enc_clear),
    .enc_set_state(enc_set_state), .enc_start_round(enc_start_round),
    .enc_round_input(enc_round_input), .enc_round_output(enc_round_output),
    .enc_finished(enc_finished)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_block(input logic [511:0] s);
    logic [31:0]  x[16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
    for (int k = 0; k < 10; k++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[32*i +: 32];
    return r;
  endfunction

  function automatic logic [511:0] exp_state(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    return {n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  endfunction

  // Encoder model: latency LAT after start_round, clear aborts, hang suppresses finished.
  always @(posedge clock) begin
    m_fin <= 1'b0;
    if (enc_clear) begin
      m_run <= 1'b0;
      m_cnt <= 0;
    end else begin
      if (enc_set_state) m_in <= enc_round_input;
      if (enc_start_round) begin
        m_run <= 1'b1;
        m_cnt <= LAT;
      end else if (m_run) begin
        if (m_cnt == 1) begin
          m_run <= 1'b0;
          if (!hang) begin
            m_fin <= 1'b1;
            m_out <= chacha_block(m_in);
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign enc_finished     = m_fin | inj;
  assign enc_round_output = inj ? {16{32'hbad0bad0}} : m_out;

  always @(posedge clock) begin
    if (ks_valid && ks_ready) begin
      hs_cnt    <= hs_cnt + 1;
      last_data <= ks_data;
    end
    if (ks_valid)        v_cnt   <= v_cnt + 1;
    if (enc_start_round) st_cnt  <= st_cnt + 1;
    if (enc_set_state)   set_cnt <= set_cnt + 1;
    if (enc_clear)       clr_cnt <= clr_cnt + 1;
  end

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      0:       return ks_valid;
      1:       return enc_start_round;
      default: return exhausted;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (cur(sel) !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(tag, 512'(cur(sel)), 512'(1));
  endtask

  task automatic do_key_load(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    key = k; nonce = n; counter_init = c; key_load = 1'b1;
    tick(1);
    key_load = 1'b0;
    hs0 = hs_cnt; v0 = v_cnt; st0 = st_cnt; set0 = set_cnt; clr0 = clr_cnt;
  endtask

  function automatic logic [511:0] ctl_bits();
    return 512'({ks_valid, busy, exhausted, error, enc_clear, enc_set_state, enc_start_round});
  endfunction

  logic [255:0] rk;
  logic [95:0]  rn;
  logic [255:0] k1, k2;
  logic [95:0]  n1;
  logic [511:0] snap;
  logic         stable;
  localparam logic [511:0] IDLE_IN = {384'h0, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  initial begin
    for (int i = 0; i < 32; i++) rk[8*i +: 8] = 8'(i);
    rn = {32'h00000000, 32'h4a000000, 32'h09000000};
    k1 = {8{32'hdeadbeef}};
    k2 = {4{64'h0f1e2d3c4b5a6978}};
    n1 = 96'h00000001_00000002_00000003;

    // Reset state
    tick(3);
    check("rst_ctl", ctl_bits(), '0);
    check("rst_data", ks_data, '0);
    check("rst_round_in", enc_round_input, IDLE_IN);
    reset_n = 1'b1;
    tick(2);

    // RFC 8439 block function vector
    ks_ready = 1'b1;
    do_key_load(rk, rn, 32'd1);
    check("rfc_clear", 512'(enc_clear), 512'(1));
    check("rfc_state_in", enc_round_input, exp_state(rk, rn, 32'd1));
    wait_for(0, "rfc_valid");
    check("rfc_w0", 512'(ks_data[31:0]), 512'(32'he4e7f110));
    check("rfc_w1", 512'(ks_data[63:32]), 512'(32'h15593bd1));
    check("rfc_block", ks_data, chacha_block(exp_state(rk, rn, 32'd1)));
    check("rfc_ctr_next", 512'(enc_round_input[415:384]), 512'(32'd2));
    tick(1);

    // Backpressure
    ks_ready = 1'b0;
    wait_for(0, "bp_valid");
    check("bp_block", ks_data, chacha_block(exp_state(rk, rn, 32'd2)));
    snap = ks_data; set0 = set_cnt; stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (ks_data !== snap || ks_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_stable", 512'(stable), 512'(1));
    check("bp_no_set", 512'(set_cnt - set0), 512'(0));
    ks_ready = 1'b1;
    tick(1);
    check("bp_drop", 512'(ks_valid), 512'(0));
    wait_for(0, "bp_next_valid");
    check("bp_next_block", ks_data, chacha_block(exp_state(rk, rn, 32'd3)));
    check("bp_one_set", 512'(set_cnt - set0), 512'(1));

    // Exhaustion (key_load coincident with a handshake)
    do_key_load(k1, n1, 32'hFFFFFFFE);
    wait_for(2, "ex_flag");
    tick(40);
    check("ex_blocks", 512'(hs_cnt - hs0), 512'(2));
    check("ex_starts", 512'(st_cnt - st0), 512'(2));
    check("ex_last", last_data, chacha_block(exp_state(k1, n1, 32'hFFFFFFFF)));
    check("ex_idle_ctl", ctl_bits(), 512'(7'b0010000));
    check("ex_ctr_hold", 512'(enc_round_input[415:384]), 512'(32'hFFFFFFFF));

    // Rekey mid-BUSY with spurious late finished
    do_key_load(k1, n1, 32'd5);
    check("ex_cleared", 512'(exhausted), 512'(0));
    wait_for(1, "rk_start");
    tick(4);
    check("rk_busy", 512'(busy), 512'(1));
    do_key_load(k2, n1, 32'h100);
    check("rk_clear_on", 512'(enc_clear), 512'(1));
    inj = 1'b1;
    tick(1);
    check("rk_clear_off", 512'(enc_clear), 512'(0));
    tick(1);
    inj = 1'b0;
    wait_for(0, "rk_valid");
    check("rk_block", ks_data, chacha_block(exp_state(k2, n1, 32'h100)));
    check("rk_clear_cnt", 512'(clr_cnt - clr0), 512'(1));
    check("rk_ctr_next", 512'(enc_round_input[415:384]), 512'(32'h101));

    // Asynchronous reset while in HOLD
    ks_ready = 1'b0;
    do_key_load(k1, n1, 32'd7);
    wait_for(0, "ar_hold_valid");
    #2 reset_n = 1'b0;
    #1;
    check("ar_hold_ctl", ctl_bits(), '0);
    check("ar_hold_data", ks_data, '0);
    check("ar_hold_in", enc_round_input, IDLE_IN);
    @(negedge clock);
    reset_n = 1'b1;
    st0 = st_cnt;
    tick(30);
    check("ar_hold_idle", ctl_bits(), '0);
    check("ar_hold_nostart", 512'(st_cnt - st0), 512'(0));

    // Asynchronous reset while in BUSY
    ks_ready = 1'b1;
    do_key_load(k2, n1, 32'd9);
    wait_for(1, "ar_busy_start");
    tick(3);
    check("ar_busy_pre", 512'(busy), 512'(1));
    #2 reset_n = 1'b0;
    #1;
    check("ar_busy_ctl", ctl_bits(), '0);
    @(negedge clock);
    reset_n = 1'b1;
    v0 = v_cnt;
    tick(30);
    check("ar_busy_novalid", 512'(v_cnt - v0), 512'(0));

    // Watchdog with a hung encoder
    hang = 1'b1;
    do_key_load(k1, n1, 32'd11);
    wait_for(1, "wd_start");
    tick(16);
    check("wd_not_yet", 512'(error), 512'(0));
    tick(1);
    check("wd_error", 512'(error), 512'(1));
    check("wd_clear", 512'(enc_clear), 512'(1));
    check("wd_idle", 512'(busy), 512'(0));
    tick(1);
    check("wd_clear_pulse", 512'(enc_clear), 512'(0));
    check("wd_novalid", 512'(v_cnt - v0), 512'(0));
    hang = 1'b0;
    do_key_load(k1, n1, 32'd12);
    check("wd_err_cleared", 512'(error), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chacha20_keystream_sequencer.md
Name: chacha20_keystream_sequencer

Overview:
- Controller that drives one `chacha20_serial_encoder` instance to produce a continuous ChaCha20 keystream (RFC 8439 block function).
- Holds key, nonce and block counter, builds the 512-bit initial state, and sequences `set_state` / `start_round`.
- Captures `round_output` into a buffer and presents it on a valid/ready stream; the block counter advances per block.
- Sits between the encoder and keystream consumers (XOR stage, LED/RNG demo top).

Parameters:
- WATCHDOG_CYCLES, 1024: max cycles in BUSY waiting for `enc_finished` before flagging error; 0 disables the watchdog.

Ports:
- clock  in  1  sole clock
- reset_n  in  1  reset; asynchronous, active-low
- key_load  in  1  one-cycle pulse; latch key/nonce/counter_init and (re)start the stream
- key  in  256  key; word i = bits[32i+31:32i], little-endian words per RFC 8439
- nonce  in  96  nonce; word i = bits[32i+31:32i]
- counter_init  in  32  initial block counter
- ks_valid  out  1  keystream block available
- ks_ready  in  1  consumer accepts block
- ks_data  out  512  keystream block (state word i at bits[32i+31:32i])
- busy  out  1  high in LOAD/START/BUSY
- exhausted  out  1  counter space used up; sticky until key_load
- error  out  1  watchdog expired; sticky until key_load
- enc_clear  out  1  to encoder `clear`
- enc_set_state  out  1  to encoder `set_state`
- enc_start_round  out  1  to encoder `start_round`
- enc_round_input  out  512  to encoder `round_input`
- enc_round_output  in  512  from encoder `round_output`
- enc_finished  in  1  from encoder `finished`

Behaviour:
- Encoder contract:
  - `set_state`=1 loads `round_input` on that edge.
  - One-cycle `start_round` begins 20 rounds.
  - `finished` pulses one cycle with `round_output` valid (feed-forward already added).
  - `clear`=1 synchronously aborts and resets the encoder.
- Reset values:
  - state IDLE; ks_valid=0, ks_data=0, busy=0, exhausted=0, error=0.
  - enc_clear=0, enc_set_state=0, enc_start_round=0; key/nonce/counter regs=0.
- enc_round_input is combinational from registers:
  - words 0..3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574;
  - words 4..11 = key; word 12 = counter; words 13..15 = nonce.
- FSM states IDLE, LOAD, START, BUSY, HOLD. All control outputs are registered, one cycle per state.
  - IDLE: waits for key_load.
  - LOAD: enc_set_state=1 for exactly one cycle, then START.
  - START: enc_start_round=1 for exactly one cycle, then BUSY.
  - BUSY: waits for enc_finished. On that edge: ks_data<=enc_round_output, ks_valid<=1, go HOLD.
    - If counter==0xFFFFFFFF: set exhausted, counter unchanged. Otherwise counter<=counter+1 (32-bit, never wraps).
  - HOLD: when ks_valid&ks_ready, drop ks_valid and go LOAD (or IDLE if exhausted). With ks_ready held high, throughput is one block per (encoder latency + 3) cycles.
- key_load in any state:
  - Latch key/nonce/counter_init; clear exhausted, error and ks_valid.
  - Assert enc_clear for one cycle (next cycle); go LOAD the cycle after that. Any in-flight or unaccepted block is discarded.
  - key_load coincident with ks_valid&ks_ready: the handshake completes first (block consumed), then the key_load is applied.
  - key_load coincident with enc_finished: key_load wins, and the output is dropped.
- enc_finished outside BUSY is ignored.
- ks_data is stable while ks_valid=1 and ks_ready=0.
- Watchdog counts cycles in BUSY. On reaching WATCHDOG_CYCLES: error=1, enc_clear pulse, go IDLE, ks_valid stays 0.
- reset_n low mid-operation: immediate return to reset values, with no partial block emitted.

Decomposition:
- Shared package chacha20_pkg holds:
  - the four sigma constants;
  - widths (KEY_W=256, NONCE_W=96, CTR_W=32, BLOCK_W=512);
  - the FSM state enum;
  - the state-assembly function (key, nonce, counter -> 512-bit state).
- No sub-module is needed: FSM plus datapath registers in one module. The encoder is instantiated by the parent, not inside this block.

Test Plan:
- RFC 8439 §2.3.2 vector:
  - stimulus: key=00..1f, nonce=000000090000004a00000000, counter_init=1, ks_ready=1.
  - response: first ks_data word0=0xe4e7f110, word1=0x15593bd1; state word 12 of the next enc_round_input = 2.
- Backpressure: ks_ready=0 for 50 cycles after ks_valid -> ks_data stable, no enc_set_state pulse until ks_ready rises; the next block uses counter+1.
- Exhaustion:
  - counter_init=0xFFFFFFFE -> two blocks emitted (counters FFFFFFFE, FFFFFFFF), exhausted=1, FSM IDLE, no further enc_start_round.
  - key_load then clears exhausted.
- Rekey mid-BUSY: key_load 5 cycles after enc_start_round -> enc_clear one-cycle pulse, late enc_finished ignored, next block computed with the new key/counter only.
- Watchdog: enc_finished tied 0 with WATCHDOG_CYCLES=16 -> error=1 exactly 16 cycles into BUSY, enc_clear pulse, ks_valid never asserts.
- Async reset: reset_n low in HOLD and in BUSY -> all outputs 0 immediately, without waiting for a clock edge; idle until key_load.
